// File: rtl/hub75_bcm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : hub75_bcm_driver
//  Function : HUB75 panel scan engine with binary-coded modulation. Reads
//             pixels from a one-cycle-latency framebuffer port, shifts one
//             bit-plane per row into the panel, latches it and shows it for
//             BASE_CYCLES << plane cycles. The next plane shifts in while the
//             current one is shown.
//  Timing   : o_fb_rd/o_fb_addr are valid during the fetch states. The panel
//             lines are registered from the state they belong to, so they
//             change on the clock edge that leaves that state. As a result
//             o_rgb_* settle a full cycle before o_panel_clock rises.
//  Revision : 1.0  initial release
// ============================================================================
module hub75_bcm_driver #(
   parameter int COLS        = 64,
   parameter int ROWS        = 64,
   parameter int COLOR_DEPTH = 4,
   parameter int BASE_CYCLES = 32
) (
   input  logic                                   i_clock,
   input  logic                                   i_reset,
   input  logic                                   i_enable,
   output logic [$clog2(ROWS)+$clog2(COLS)-1:0]   o_fb_addr,
   output logic                                   o_fb_rd,
   input  logic [3*COLOR_DEPTH-1:0]               i_fb_data,
   output logic                                   o_panel_clock,
   output logic                                   o_latch,
   output logic                                   o_blank,
   output logic [$clog2(ROWS/2)-1:0]              o_address,
   output logic [2:0]                             o_rgb_0,
   output logic [2:0]                             o_rgb_1,
   output logic                                   o_frame_done
);

   localparam int c_col_bits   = $clog2(COLS);
   localparam int c_addr_bits  = $clog2(ROWS/2);
   localparam int c_plane_bits = (COLOR_DEPTH > 1) ? $clog2(COLOR_DEPTH) : 1;
   localparam int c_cnt_bits   = $clog2((BASE_CYCLES << (COLOR_DEPTH-1)) + 1);

   localparam logic [c_col_bits-1:0]   c_col_last   = c_col_bits'(COLS-1);
   localparam logic [c_col_bits-1:0]   c_col_one    = c_col_bits'(1);
   localparam logic [c_addr_bits-1:0]  c_row_last   = c_addr_bits'(ROWS/2-1);
   localparam logic [c_addr_bits-1:0]  c_row_one    = c_addr_bits'(1);
   localparam logic [c_plane_bits-1:0] c_plane_last = c_plane_bits'(COLOR_DEPTH-1);
   localparam logic [c_plane_bits-1:0] c_plane_one  = c_plane_bits'(1);
   localparam logic [c_cnt_bits-1:0]   c_cnt_one    = c_cnt_bits'(1);
   localparam logic [c_cnt_bits-1:0]   c_base       = c_cnt_bits'(BASE_CYCLES);

   typedef enum logic [3:0] {
      S_IDLE      = 4'd0,
      S_FETCH_TOP = 4'd1,
      S_FETCH_BOT = 4'd2,
      S_SETUP     = 4'd3,
      S_CLK_HI    = 4'd4,
      S_CLK_LO    = 4'd5,
      S_WAIT      = 4'd6,
      S_LATCH_HI  = 4'd7,
      S_LATCH_LO  = 4'd8,
      S_UNBLANK   = 4'd9
   } state_t;

   state_t                  state_q;
   logic [c_addr_bits-1:0]  row_q;
   logic [c_plane_bits-1:0] plane_q;
   logic [c_col_bits-1:0]   col_q;
   logic [c_cnt_bits-1:0]   cnt_q;
   logic [c_cnt_bits-1:0]   weight_q;

   logic [COLOR_DEPTH-1:0]  w_pix_r;
   logic [COLOR_DEPTH-1:0]  w_pix_g;
   logic [COLOR_DEPTH-1:0]  w_pix_b;
   logic [2:0]              w_plane_bits;
   logic [c_col_bits-1:0]   w_col_dec;
   logic [c_cnt_bits-1:0]   w_weight;
   logic                    w_last_plane;

   assign w_pix_r      = i_fb_data[3*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_pix_g      = i_fb_data[2*COLOR_DEPTH-1 -: COLOR_DEPTH];
   assign w_pix_b      = i_fb_data[COLOR_DEPTH-1:0];
   // current bit-plane of the pixel on the read port, ordered {b, g, r}
   assign w_plane_bits = {w_pix_b[plane_q], w_pix_g[plane_q], w_pix_r[plane_q]};
   assign w_col_dec    = col_q - c_col_one;
   assign w_weight     = c_base << plane_q;
   assign w_last_plane = (row_q == c_row_last) && (plane_q == c_plane_last);

   // Scan FSM: fetch/shift columns, wait out the display, latch, unblank
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state_q       <= S_IDLE;
         row_q         <= '0;
         plane_q       <= '0;
         col_q         <= c_col_last;
         cnt_q         <= '0;
         weight_q      <= '0;
         o_fb_addr     <= '0;
         o_fb_rd       <= 1'b0;
         o_panel_clock <= 1'b0;
         o_latch       <= 1'b0;
         o_blank       <= 1'b1;
         o_address     <= '0;
         o_rgb_0       <= '0;
         o_rgb_1       <= '0;
         o_frame_done  <= 1'b0;
      end else begin
         // display timer runs down in every state; loads below override it
         if (cnt_q != '0) begin
            cnt_q <= cnt_q - c_cnt_one;
         end
         o_frame_done <= 1'b0;

         case (state_q)
            S_IDLE: begin
               o_blank <= 1'b1;
               cnt_q   <= '0;
               col_q   <= c_col_last;
               if (i_enable) begin
                  o_fb_addr <= {1'b0, row_q, c_col_last};
                  o_fb_rd   <= 1'b1;
                  state_q   <= S_FETCH_TOP;
               end
            end
            S_FETCH_TOP: begin
               // bottom half is the same row offset by ROWS/2 (top address bit)
               o_fb_addr <= {1'b1, row_q, col_q};
               o_fb_rd   <= 1'b1;
               state_q   <= S_FETCH_BOT;
            end
            S_FETCH_BOT: begin
               o_fb_rd <= 1'b0;
               o_rgb_0 <= w_plane_bits;
               state_q <= S_SETUP;
            end
            S_SETUP: begin
               o_rgb_1 <= w_plane_bits;
               state_q <= S_CLK_HI;
            end
            S_CLK_HI: begin
               o_panel_clock <= 1'b1;
               state_q       <= S_CLK_LO;
            end
            S_CLK_LO: begin
               o_panel_clock <= 1'b0;
               if (col_q == '0) begin
                  state_q <= S_WAIT;
               end else begin
                  col_q     <= w_col_dec;
                  o_fb_addr <= {1'b0, row_q, w_col_dec};
                  o_fb_rd   <= 1'b1;
                  state_q   <= S_FETCH_TOP;
               end
            end
            S_WAIT: begin
               if (cnt_q == '0) begin
                  o_blank <= 1'b1;
                  if (i_enable) begin
                     state_q <= S_LATCH_HI;
                  end else begin
                     row_q   <= '0;
                     plane_q <= '0;
                     col_q   <= c_col_last;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_LATCH_HI: begin
               o_latch      <= 1'b1;
               o_address    <= row_q;
               o_frame_done <= w_last_plane;
               weight_q     <= w_weight;
               state_q      <= S_LATCH_LO;
            end
            S_LATCH_LO: begin
               o_latch <= 1'b0;
               if (plane_q == c_plane_last) begin
                  plane_q <= '0;
                  row_q   <= (row_q == c_row_last) ? '0 : row_q + c_row_one;
               end else begin
                  plane_q <= plane_q + c_plane_one;
               end
               state_q <= S_UNBLANK;
            end
            S_UNBLANK: begin
               o_blank   <= 1'b0;
               cnt_q     <= weight_q;
               col_q     <= c_col_last;
               o_fb_addr <= {1'b0, row_q, c_col_last};
               o_fb_rd   <= 1'b1;
               state_q   <= S_FETCH_TOP;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
